d0_fifo_reader: RTL

// - Read-side controller for the D0 output FIFO (1-cycle registered read, rd_enable-driven).
// - Pops the FIFO whenever data is present and downstream has room, and re-times read data into a 2-entry skid buffer.
// - Presents the data on a valid/ready port to the next transmit stage.
// - Owns the FIFO threshold (Umbral) programming during init, and latches the FIFO error flag.

---
 rtl/d0_pkg.sv | 28 ++
 rtl/d0_fifo_reader_if.sv | 29 ++
 rtl/d0_skid_buffer.sv | 67 ++++++
 rtl/d0_fifo_reader.sv | 113 +++++++++++
 4 files changed

// File: rtl/d0_pkg.sv
// Shared definitions for the D0 output FIFO read path: FSM state encoding,
// default widths, skid depth and the read-issue occupancy rule.
package d0_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'b000,
        ST_INIT   = 3'b001,
        ST_IDLE   = 3'b010,
        ST_ACTIVE = 3'b011,
        ST_ERROR  = 3'b100
    } d0_state_t;

    localparam int D0_DATA_WIDTH   = 6;
    localparam int D0_UMBRAL_WIDTH = 4;
    localparam int D0_SKID_DEPTH   = 2;

    // A new pop may be issued only if, after this cycle's hand-off, the
    // buffered words plus the word already in flight leave a free slot.
    // Evaluated in 3 bits; a hand-off implies count>=1, so no underflow.
    function automatic logic can_issue(input logic [1:0] count,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return (occ < 3'd2);
    endfunction

endpackage

// File: rtl/d0_fifo_reader_if.sv
// FIFO-side and downstream-side signals of the D0 reader. The reader uses
// the master view, the FIFO/transmit environment uses the slave view.
interface d0_fifo_reader_if
    import d0_pkg::*;
#(
    parameter int DATA_WIDTH   = D0_DATA_WIDTH,
    parameter int UMBRAL_WIDTH = D0_UMBRAL_WIDTH
) ();

    logic                    fifo_empty;
    logic                    fifo_error;
    logic [DATA_WIDTH-1:0]   fifo_data;
    logic                    fifo_rd_enable;
    logic [UMBRAL_WIDTH-1:0] umbral_out;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        input  fifo_empty, fifo_error, fifo_data, out_ready,
        output fifo_rd_enable, umbral_out, out_data, out_valid
    );

    modport slave (
        output fifo_empty, fifo_error, fifo_data, out_ready,
        input  fifo_rd_enable, umbral_out, out_data, out_valid
    );

endinterface

// File: rtl/d0_skid_buffer.sv
// Two-entry skid buffer between the FIFO read port and the valid/ready
// output. Flush dominates both write and pop in the same cycle.
module d0_skid_buffer
    import d0_pkg::*;
#(
    parameter int DATA_WIDTH = D0_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [D0_SKID_DEPTH];
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            count_reg;

    logic wr_ok;
    logic pop_ok;

    assign wr_ok  = wr & ~flush;
    assign pop_ok = pop & ~flush & (count_reg != 2'd0);

    // Pointer and occupancy bookkeeping; simultaneous write and pop keep
    // the count and advance both pointers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (wr_ok)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok)
                rd_ptr_reg <= ~rd_ptr_reg;
            case ({wr_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage array; contents need no reset because head is masked when empty.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr_reg] <= wr_data;
    end

    assign count = count_reg;
    assign head  = (count_reg != 2'd0) ? mem[rd_ptr_reg] : '0;

    // The read-issue rule guarantees a free slot for every word in flight.
    no_write_when_full: assert property (
        @(posedge clk) disable iff (!reset_L) !(wr_ok && count_reg == 2'd2)
    );

endmodule

// File: rtl/d0_fifo_reader.sv
// Read-side controller of the D0 output FIFO: programs the threshold during
// init, issues pops while downstream has room, re-times read data through a
// 2-entry skid buffer and latches FIFO errors until the next soft init.
module d0_fifo_reader
    import d0_pkg::*;
#(
    parameter int DATA_WIDTH   = D0_DATA_WIDTH,
    parameter int UMBRAL_WIDTH = D0_UMBRAL_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic [UMBRAL_WIDTH-1:0] umbral_in,
    d0_fifo_reader_if.master        io,
    output logic [2:0]              state_out,
    output logic                    error_out
);

    d0_state_t state_reg;
    d0_state_t state_next;

    logic                    inflight_reg;
    logic [UMBRAL_WIDTH-1:0] umbral_reg;
    logic                    error_reg;

    logic [1:0]              skid_count;
    logic [DATA_WIDTH-1:0]   skid_head;
    logic                    out_valid;
    logic                    pop;
    logic                    rd_enable;
    logic                    flush;
    logic                    skid_wr;

    assign out_valid = (skid_count != 2'd0);
    assign pop       = out_valid & io.out_ready;
    assign rd_enable = (state_reg == ST_ACTIVE) & ~io.fifo_empty & init
                     & can_issue(skid_count, inflight_reg, pop);

    // Leaving the streaming states empties the buffer on that same edge, so
    // INIT and ERROR never present stale data; the word in flight is dropped.
    assign flush   = !((state_next == ST_IDLE) || (state_next == ST_ACTIVE));
    assign skid_wr = inflight_reg & ~flush;

    // Next-state selection: soft init overrides everything, error precedes empty.
    always_comb begin
        state_next = state_reg;
        if (!init) begin
            state_next = ST_INIT;
        end else begin
            case (state_reg)
                ST_RESET:  state_next = ST_INIT;
                ST_INIT:   state_next = ST_IDLE;
                ST_IDLE: begin
                    if (io.fifo_error)
                        state_next = ST_ERROR;
                    else if (!io.fifo_empty)
                        state_next = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (io.fifo_error)
                        state_next = ST_ERROR;
                    else if (io.fifo_empty && !inflight_reg && skid_count == 2'd0)
                        state_next = ST_IDLE;
                end
                ST_ERROR:  state_next = ST_ERROR;
                default:   state_next = ST_RESET;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            state_reg <= ST_RESET;
        else
            state_reg <= state_next;
    end

    // In-flight flag, threshold programming and sticky error flag.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            inflight_reg <= 1'b0;
            umbral_reg   <= '0;
            error_reg    <= 1'b0;
        end else begin
            inflight_reg <= rd_enable;
            if (state_reg == ST_INIT)
                umbral_reg <= umbral_in;
            error_reg <= (state_next == ST_ERROR);
        end
    end

    d0_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset_L (reset_L),
        .wr      (skid_wr),
        .wr_data (io.fifo_data),
        .pop     (pop),
        .flush   (flush),
        .count   (skid_count),
        .head    (skid_head)
    );

    assign io.fifo_rd_enable = rd_enable;
    assign io.umbral_out     = umbral_reg;
    assign io.out_valid      = out_valid;
    assign io.out_data       = skid_head;
    assign state_out         = state_reg;
    assign error_out         = error_reg;

endmodule
